// File: rtl/bp_be_instr_encoder.sv
// Packs RISC-V R-type field tuples into 32-bit instructions and queues them
// in a small FIFO; rejects tuples whose opcode low bits are not 2'b11.
module bp_be_instr_encoder #(
  parameter int depth_p     = 4,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [6:0]             opcode_i,
  input  logic [4:0]             rd_addr_i,
  input  logic [2:0]             funct3_i,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
  input  logic [6:0]             funct7_i,
  output logic [31:0]            instr_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic                   illegal_o,
  output logic [cnt_width_p-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam logic [ptr_w_lp:0] occ_full_lp  = (ptr_w_lp+1)'(depth_p);
  localparam logic [ptr_w_lp:0] occ_empty_lp = {(ptr_w_lp+1){1'b0}};

  function automatic logic is_legal(input logic [6:0] opcode);
    return (opcode[1:0] == 2'b11);
  endfunction

  function automatic logic [31:0] pack_instr(
    input logic [6:0] opcode, input logic [4:0] rd, input logic [2:0] funct3,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] funct7);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  logic [31:0]            mem_q [depth_p];
  logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp:0]      occ_q, occ_d;
  logic                   ready_en_q;
  logic                   illegal_q, illegal_d;
  logic [cnt_width_p-1:0] count_q, count_d;
  logic                   accept_s, enq_s, deq_s;

  // ready_en_q gates acceptance until the first edge after reset release
  assign ready_o   = ready_en_q && (occ_q < occ_full_lp);
  assign v_o       = (occ_q != occ_empty_lp);
  assign instr_o   = v_o ? mem_q[rd_ptr_q] : 32'd0;
  assign illegal_o = illegal_q;
  assign count_o   = count_q;

  // Next-state for pointers, occupancy, illegal pulse and consumed count
  always_comb begin
    accept_s  = v_i && ready_o;
    enq_s     = accept_s && is_legal(opcode_i);
    deq_s     = yumi_i && v_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    count_d   = count_q;
    illegal_d = accept_s && !is_legal(opcode_i);

    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
      count_d  = count_q + cnt_width_p'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
    end

    case ({enq_s, deq_s})
      2'b10:   occ_d = occ_q + (ptr_w_lp+1)'(1);
      2'b01:   occ_d = occ_q - (ptr_w_lp+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= {ptr_w_lp{1'b0}};
      rd_ptr_q   <= {ptr_w_lp{1'b0}};
      occ_q      <= occ_empty_lp;
      ready_en_q <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= {cnt_width_p{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ready_en_q <= 1'b1;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= pack_instr(opcode_i, rd_addr_i, funct3_i,
                                    rs1_addr_i, rs2_addr_i, funct7_i);
    end
  end

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Directed self-checking bench for bp_be_instr_encoder; a second instance with
// a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_bp_be_instr_encoder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, yumi_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic [2:0]  funct3_i;
  logic        ready_o, v_o, illegal_o;
  logic [31:0] instr_o;
  logic [15:0] count_o;
  logic        ready4_o, v4_o, illegal4_o;
  logic [31:0] instr4_o;
  logic [3:0]  count4_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_instr_encoder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .funct7_i(funct7_i),
    .instr_o(instr_o), .v_o(v_o), .yumi_i(yumi_i), .illegal_o(illegal_o),
    .count_o(count_o));

  bp_be_instr_encoder #(.depth_p(4), .cnt_width_p(4)) dut4 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready4_o),
    .opcode_i(opcode_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .funct7_i(funct7_i),
    .instr_o(instr4_o), .v_o(v4_o), .yumi_i(yumi_i), .illegal_o(illegal4_o),
    .count_o(count4_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_tuple(input logic [6:0] op, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [6:0] f7);
    opcode_i = op; rd_addr_i = rd; funct3_i = f3;
    rs1_addr_i = rs1; rs2_addr_i = rs2; funct7_i = f7;
  endtask

  // addi-style tuple: opcode 0x13, rs1=1, rd=n -> 0x00008013 | n<<7
  task automatic set_seq(input int n);
    set_tuple(7'h13, 5'(n), 3'd0, 5'd1, 5'd0, 7'h00);
  endtask

  function automatic logic [31:0] seq_exp(input int n);
    return 32'h0000_8013 | (32'(n) << 7);
  endfunction

  task automatic do_reset();
    v_i = 1'b0; yumi_i = 1'b0;
    reset_n_i = 1'b0;
    repeat (2) step();
    reset_n_i = 1'b1;
    step();
  endtask

  initial begin
    v_i = 1'b0; yumi_i = 1'b0;
    set_tuple(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0);
    reset_n_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    repeat (2) step();
    // offer a tuple across release: must not be taken before ready_o rises
    set_tuple(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20);
    v_i = 1'b1;
    reset_n_i = 1'b1;
    #1 chk("ready_pre_edge", 32'(ready_o), 32'd0);
    step();
    v_i = 1'b0;
    chk("ready_after_edge", 32'(ready_o), 32'd1);
    chk("no_accept_pre_ready", 32'(v_o), 32'd0);

    // single legal tuple
    set_tuple(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20);
    v_i = 1'b1;
    #1 chk("no_bypass", 32'(v_o), 32'd0);
    step();
    v_i = 1'b0;
    chk("single_v", 32'(v_o), 32'd1);
    chk("single_instr", instr_o, 32'h4073_02B3);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    chk("single_count", 32'(count_o), 32'd1);
    chk("single_empty", 32'(v_o), 32'd0);

    // illegal tuple
    do_reset();
    set_tuple(7'h32, 5'd1, 3'd0, 5'd2, 5'd3, 7'h00);
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    chk("illegal_pulse", 32'(illegal_o), 32'd1);
    chk("illegal_v", 32'(v_o), 32'd0);
    chk("illegal_count", 32'(count_o), 32'd0);
    step();
    chk("illegal_one_cycle", 32'(illegal_o), 32'd0);
    chk("illegal_v2", 32'(v_o), 32'd0);

    // yumi while empty is ignored
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    chk("yumi_empty_count", 32'(count_o), 32'd0);

    // fill to full, offer a 5th, then drain in order
    for (int i = 1; i <= 4; i++) begin
      set_seq(i);
      v_i = 1'b1;
      step();
    end
    chk("full_ready", 32'(ready_o), 32'd0);
    set_seq(31);
    step();
    v_i = 1'b0;
    chk("full_ready_hold", 32'(ready_o), 32'd0);
    chk("full_head_stable", instr_o, seq_exp(1));
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), instr_o, seq_exp(i));
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    chk("drain_empty", 32'(v_o), 32'd0);
    chk("drain_count", 32'(count_o), 32'd4);

    // simultaneous enqueue/dequeue at occupancy 1
    do_reset();
    set_seq(0);
    v_i = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("flow_%0d", k), instr_o, seq_exp(k));
      set_seq(k + 1);
      v_i = 1'b1;
      yumi_i = 1'b1;
      step();
    end
    v_i = 1'b0; yumi_i = 1'b0;
    chk("flow_v", 32'(v_o), 32'd1);
    chk("flow_head", instr_o, seq_exp(10));
    chk("flow_count", 32'(count_o), 32'd10);
    // illegal tuple on a dequeue edge: only the dequeue takes effect
    set_tuple(7'h30, 5'd9, 3'd1, 5'd2, 5'd3, 7'h01);
    v_i = 1'b1; yumi_i = 1'b1;
    step();
    v_i = 1'b0; yumi_i = 1'b0;
    chk("ill_deq_pulse", 32'(illegal_o), 32'd1);
    chk("ill_deq_v", 32'(v_o), 32'd0);
    chk("ill_deq_count", 32'(count_o), 32'd11);

    // reset with entries in flight
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_seq(i);
      v_i = 1'b1;
      step();
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    chk("mid_count_pre", 32'(count_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", 32'(v_o), 32'd0);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_instr", instr_o, 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    step();
    reset_n_i = 1'b1;
    step();
    chk("mid_post_v", 32'(v_o), 32'd0);
    chk("mid_post_ready", 32'(ready_o), 32'd1);

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_seq(i);
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    chk("wrap_count16", 32'(count_o), 32'd17);
    chk("wrap_count4", 32'(count4_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
